// File: rtl/audio_dma.sv
// rtl/audio_dma.sv - memory-to-audio-FIFO sample streamer with register port
module audio_dma #(
  parameter int BUFFER_SIZE = 4096,
  parameter int QUEUE_LOW   = 1024,
  parameter int POLL_GAP    = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [3:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_audio_request,
  output logic        o_audio_rw,
  output logic [3:0]  o_audio_address,
  output logic [15:0] o_audio_wdata,
  input  logic [31:0] i_audio_rdata,
  input  logic        i_audio_ready
);

  // A refill threshold above the FIFO depth can never be reached, so clamp it.
  localparam int LOW_C = (QUEUE_LOW > BUFFER_SIZE) ? BUFFER_SIZE : QUEUE_LOW;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_POLL_END, S_POLL_WAIT, S_FETCH, S_PUSH_LO, S_PUSH_HI, S_ADVANCE
  } state_t;

  state_t      r_state, w_next;
  logic        r_phase, w_phase_next;
  logic        r_enable, r_loop, r_irq_en, r_busy, r_done;
  logic [31:0] r_base, r_length, r_cur_addr, r_remain, r_word, r_rdata;
  logic [15:0] r_queued;
  logic [GAP_W-1:0] r_gap;
  logic        r_ready, r_irq, r_bus_req, r_audio_req;

  logic        w_cpu_access, w_audio_hs, w_bus_hs, w_gap_done;
  logic        w_bus_req_next, w_audio_req_next;
  logic        w_start, w_zero_len, w_latch_q, w_latch_w, w_advance, w_finish, w_stop, w_reload;
  logic [31:0] w_read_mux;
  logic        w_unused_audio_rdata;

  assign w_cpu_access = i_request && !r_ready;
  assign w_audio_hs   = r_audio_req && i_audio_ready;
  assign w_bus_hs     = r_bus_req && i_bus_ready;
  assign w_gap_done   = (r_gap == GAP_W'(POLL_GAP - 1));
  assign w_unused_audio_rdata = ^i_audio_rdata[31:16];

  assign o_rdata         = r_rdata;
  assign o_ready         = r_ready;
  assign o_interrupt     = r_irq;
  assign o_bus_request   = r_bus_req;
  assign o_bus_address   = r_cur_addr;
  assign o_audio_request = r_audio_req;
  assign o_audio_rw      = (r_state == S_PUSH_LO) || (r_state == S_PUSH_HI);
  assign o_audio_address = 4'd0;
  assign o_audio_wdata   = (r_state == S_PUSH_HI) ? r_word[31:16] : r_word[15:0];

  // Register file read view, captured on the first cycle of a CPU access.
  always_comb begin
    w_read_mux = 32'd0;
    case (i_address)
      4'd0: w_read_mux = {29'd0, r_irq_en, r_loop, r_enable};
      4'd1: w_read_mux = r_base;
      4'd2: w_read_mux = r_length;
      4'd3: w_read_mux = {30'd0, r_done, r_busy};
      4'd4: w_read_mux = r_cur_addr;
      4'd5: w_read_mux = r_remain;
      default: w_read_mux = 32'd0;
    endcase
  end

  // Sequencer next state; each master state requests first, then waits for ready to drop.
  always_comb begin
    w_next           = r_state;
    w_phase_next     = r_phase;
    w_bus_req_next   = 1'b0;
    w_audio_req_next = 1'b0;
    w_start          = 1'b0;
    w_zero_len       = 1'b0;
    w_latch_q        = 1'b0;
    w_latch_w        = 1'b0;
    w_advance        = 1'b0;
    w_finish         = 1'b0;
    w_stop           = 1'b0;
    w_reload         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable) begin
          if (r_length != 32'd0) begin
            w_start = 1'b1;
            w_next  = S_POLL;
          end else begin
            w_zero_len = 1'b1;
          end
        end
      end
      S_POLL: begin
        if (w_audio_hs) begin
          w_latch_q = 1'b1;
          w_next    = S_POLL_END;
        end else begin
          w_audio_req_next = 1'b1;
        end
      end
      S_POLL_END: begin
        if (!i_audio_ready) begin
          if (!r_enable) begin
            w_stop = 1'b1;
            w_next = S_IDLE;
          end else if (r_queued < 16'(LOW_C)) begin
            w_next = S_FETCH;
          end else begin
            w_next = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (!r_enable) begin
          w_stop = 1'b1;
          w_next = S_IDLE;
        end else if (w_gap_done) begin
          w_next = S_POLL;
        end
      end
      S_FETCH: begin
        if (!r_phase) begin
          if (w_bus_hs) begin
            w_latch_w    = 1'b1;
            w_phase_next = 1'b1;
          end else begin
            w_bus_req_next = 1'b1;
          end
        end else if (!i_bus_ready) begin
          w_phase_next = 1'b0;
          w_next       = S_PUSH_LO;
        end
      end
      S_PUSH_LO, S_PUSH_HI: begin
        if (!r_phase) begin
          if (w_audio_hs) begin
            w_phase_next = 1'b1;
          end else begin
            w_audio_req_next = 1'b1;
          end
        end else if (!i_audio_ready) begin
          w_phase_next = 1'b0;
          w_next       = (r_state == S_PUSH_LO) ? S_PUSH_HI : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        w_advance = 1'b1;
        if (r_remain == 32'd1) begin
          w_finish = 1'b1;
          if (r_loop && r_enable && (r_length != 32'd0)) begin
            w_reload = 1'b1;
            w_next   = S_POLL;
          end else begin
            w_stop = 1'b1;
            w_next = S_IDLE;
          end
        end else if (!r_enable) begin
          w_stop = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_POLL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
    end
  end

  // Registers, handshake outputs and datapath; sequencer updates override CPU writes, DONE set beats clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_enable    <= 1'b0;
      r_loop      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_base      <= 32'd0;
      r_length    <= 32'd0;
      r_cur_addr  <= 32'd0;
      r_remain    <= 32'd0;
      r_word      <= 32'd0;
      r_rdata     <= 32'd0;
      r_queued    <= 16'd0;
      r_gap       <= '0;
      r_ready     <= 1'b0;
      r_irq       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_audio_req <= 1'b0;
    end else begin
      r_ready     <= i_request;
      r_bus_req   <= w_bus_req_next;
      r_audio_req <= w_audio_req_next;
      r_irq       <= w_finish && r_irq_en;
      if (w_cpu_access) begin
        r_rdata <= w_read_mux;
        if (i_rw) begin
          case (i_address)
            4'd0: {r_irq_en, r_loop, r_enable} <= i_wdata[2:0];
            4'd1: r_base <= {i_wdata[31:2], 2'b00};
            4'd2: r_length <= i_wdata;
            4'd3: if (i_wdata[1]) r_done <= 1'b0;
            default: ;
          endcase
        end
      end
      if (w_start) begin
        r_cur_addr <= r_base;
        r_remain   <= r_length;
        r_busy     <= 1'b1;
      end
      if (w_zero_len) r_enable <= 1'b0;
      if (w_latch_q) r_queued <= i_audio_rdata[15:0];
      if (w_latch_w) r_word <= i_bus_rdata;
      if (w_advance) begin
        if (w_reload) begin
          r_cur_addr <= r_base;
          r_remain   <= r_length;
        end else begin
          r_cur_addr <= r_cur_addr + 32'd4;
          r_remain   <= r_remain - 32'd1;
        end
      end
      if (w_finish) r_done <= 1'b1;
      if (w_stop) begin
        r_enable <= 1'b0;
        r_busy   <= 1'b0;
      end
      r_gap <= ((r_state == S_POLL_WAIT) && (w_next == S_POLL_WAIT)) ? r_gap + 1'b1 : '0;
    end
  end

endmodule
